uart_receive: RTL
=================

// Module: uart_receive
// PURPOSE
//   8N1 asynchronous serial receiver; the receive-side counterpart of the board UART transmitter.
//   Samples the serial line on CLOCK_50 and presents each received byte on a one-entry valid/ready holding register.
//   Flags framing errors and overruns.
//   Sits between the debug header pin and host-side logic: test harness command/byte injection into CPU/PPU stub memory.
// PARAMETERS
//   CLK_HZ   50_000_000  system clock frequency in Hz
//   BAUD     115_200     line rate in bits/s
//   SYNC_FF  2           synchronizer depth on RX, >=2
//   CPB (localparam) = CLK_HZ/BAUD clocks per bit, integer divide; required CPB >= 4
// PORTS
//   CLOCK_50     in   1  system clock; all logic on posedge
//   RESET_N      in   1  reset, asynchronous assert, active-low
//   RX           in   1  serial line, idle high, asynchronous to CLOCK_50
//   data         out  8  received byte; stable while data_valid=1
//   data_valid   out  1  holding register full
//   data_ready   in   1  consumer accepts; byte consumed on cycle with data_valid & data_ready
//   frame_err    out  1  one-cycle pulse: stop bit sampled low
//   overrun      out  1  one-cycle pulse: byte completed while holding register full and not being consumed
//   busy         out  1  high in any state except IDLE
// BEHAVIOUR
//   Reset (async, RESET_N=0): state=IDLE, synchronizer flops=1, bit counter=0, cycle counter=0,
//     data=8'h00, data_valid=0, frame_err=0, overrun=0, busy=0.
//   Reset mid-frame: partial byte discarded; after release, wait for RX high before detecting a start bit.
//   rx_s = RX after SYNC_FF flops; all decisions use rx_s (SYNC_FF cycles input latency).
//   FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
//     IDLE: rx_s=0 -> START, cnt=0.
//     START: at cnt=CPB/2-1 sample rx_s.
//       rx_s=1: glitch; -> IDLE, no flags.
//       rx_s=0: -> DATA, cnt=0, bit=0.
//     DATA: at cnt=CPB-1 sample rx_s into shift[bit], LSB first; cnt=0.
//       bit=7 -> STOP; else bit+1.
//     STOP: at cnt=CPB-1 sample rx_s.
//       1: deliver byte; -> IDLE (mid stop bit, so next falling edge is caught).
//       0: frame_err pulse; byte discarded; -> WAIT_IDLE.
//     WAIT_IDLE: stay until rx_s=1, then -> IDLE. Break conditions produce exactly one frame_err.
//   Counters: cnt width $clog2(CPB); bit width 3; cnt reset to 0 on every state change.
//   Deliver rules, applied in the cycle after the stop sample:
//     data_valid=0, or data_ready=1 that cycle: data<=shift, data_valid<=1.
//       Simultaneous consume + deliver: valid stays 1, no overrun.
//     data_valid=1 and data_ready=0: new byte dropped, old data kept, overrun pulse.
//   Consume: data_valid & data_ready with no delivery that cycle -> data_valid<=0; data holds its last value.
//   Latency: data_valid rises 1 cycle after the stop-bit sample, i.e. about 9.5*CPB + SYNC_FF + 1 clocks after the start edge.
//   frame_err and overrun never assert together for the same frame. frame_err takes priority: nothing is delivered.
// STRUCTURE
//   Shared package uart_pkg: uart_state_e enum {IDLE,START,DATA,STOP,WAIT_IDLE}, DATA_BITS=8, cpb() function.
//     UartTransmit shares this package.
//   Sub-module sync_ff #(.DEPTH(SYNC_FF), .RST_VAL(1'b1)) for the RX synchronizer.
//   The FSM, counters, shift register and holding register are inline.
// TESTING
//   Bench uses CLK_HZ=1000, BAUD=100, so CPB=10; the driver holds each bit for 10 clocks.
//   1 Send 8'hA9, data_ready=0
//     -> data_valid=1, data=8'hA9 ~97+SYNC_FF clocks after the start edge; frame_err=0, overrun=0.
//   2 Send 8'h00 then 8'hFF back-to-back, data_ready tied 1
//     -> two 1-cycle accepts (data=00, then FF); no overrun.
//   3 Send 8'hF0, hold data_ready=0, send 8'hFA
//     -> overrun pulses once, data stays 8'hF0; then ready=1 -> data_valid=0.
//   4 Frame with stop bit driven 0, RX held low 30 more clocks
//     -> exactly one frame_err pulse; data_valid unchanged; busy until RX high.
//     Then a valid 8'h55 is received correctly.
//   5 3-clock low glitch on idle RX -> returns to IDLE; no data_valid, no flags.
//   6 Assert RESET_N=0 mid DATA of 8'hC3, release with RX low, later send 8'h3C
//     -> all outputs at reset values; no byte from the aborted frame; only 8'h3C delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and the clocks-per-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; reset value is selectable.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= {DEPTH{RST_VAL}};
    end else begin
      stage_reg <= {stage_reg[DEPTH-2:0], d};
    end
  end

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver with mid-bit sampling, a one-entry valid/ready holding register,
// and single-cycle frame_err / overrun pulses.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115_200,
  parameter int SYNC_FF = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       RX,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int              CPB      = cpb(CLK_HZ, BAUD);
  localparam int              CW       = $clog2(CPB);
  localparam logic [CW-1:0]   CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CPB - 1);
  localparam logic [2:0]      BIT_LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [2:0]           bit_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 deliver_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;
  logic [SYNC_FF-1:0]   flush_reg;
  logic                 armed_reg;

  sync_ff #(
    .DEPTH   (SYNC_FF),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .d     (RX),
    .q     (rx_s)
  );

  // Start detection is armed only once the synchronizer holds real samples and the
  // line has been seen high, so a reset released mid-frame cannot fake a start bit.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      deliver_reg   <= 1'b0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      flush_reg     <= '0;
      armed_reg     <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      deliver_reg   <= 1'b0;
      flush_reg     <= {flush_reg[SYNC_FF-2:0], 1'b1};
      if (flush_reg[SYNC_FF-1] && rx_s) begin
        armed_reg <= 1'b1;
      end

      if (deliver_reg) begin
        if (!valid_reg || data_ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && data_ready) begin
        valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (armed_reg && !rx_s) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end
        START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= IDLE;
            end else begin
              state_reg <= DATA;
              bit_reg   <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_reg == BIT_LAST) begin
              state_reg <= STOP;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              deliver_reg <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign data       = data_reg;
  assign data_valid = valid_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != IDLE);

endmodule
